// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: loader state encoding and instruction width.
package cpu_pkg;

    localparam int INSTR_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DAT_HI,
        S_DAT_LO,
        S_CHK,
        S_DONE,
        S_ERR
    } ldr_state_t;

endpackage

// File: rtl/loader_cksum.sv
// 8-bit XOR accumulator for the loader frame checksum; clear wins over enable.
module loader_cksum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] sum
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      sum <= 8'h00;
        else if (clr) sum <= 8'h00;
        else if (en)  sum <= sum ^ data;
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: writes 16-bit words into instruction RAM and holds
// the CPU in Halt until a load completes with a matching checksum.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_req,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               err
);

    // Largest legal length is exactly the RAM depth, so compare in 17 bits.
    localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

    ldr_state_t        state, state_nxt;
    logic [7:0]        len_hi;
    logic [7:0]        hi_byte;
    logic [15:0]       remaining;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        cksum;
    logic [15:0]       len_full;
    logic              len_big;
    logic              xfer;
    logic              start;
    logic              in_frame;

    assign in_frame = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DAT_HI) ||
                      (state == S_DAT_LO) || (state == S_CHK);
    assign rx_ready = in_frame;
    assign busy     = in_frame;
    assign xfer     = rx_valid & rx_ready;
    assign start    = load_req & ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    assign len_full = {len_hi, rx_data};
    assign len_big  = {1'b0, len_full} > MAX_LEN;

    loader_cksum u_cksum (
        .clk  (clk),
        .rst  (rst),
        .clr  (start),
        .en   (xfer && (state != S_CHK)),
        .data (rx_data),
        .sum  (cksum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_LEN_HI;
            S_LEN_HI: if (xfer) state_nxt = S_LEN_LO;
            S_LEN_LO: if (xfer) begin
                if (len_big)              state_nxt = S_ERR;
                else if (len_full == '0)  state_nxt = S_CHK;
                else                      state_nxt = S_DAT_HI;
            end
            S_DAT_HI: if (xfer) state_nxt = S_DAT_LO;
            S_DAT_LO: if (xfer) state_nxt = (remaining == 16'd1) ? S_CHK : S_DAT_HI;
            S_CHK:    if (xfer) state_nxt = (rx_data == cksum) ? S_DONE : S_ERR;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            addr       <= '0;
            len_hi     <= '0;
            hi_byte    <= '0;
            remaining  <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start) begin
                cpu_hold <= 1'b1;
                done     <= 1'b0;
                err      <= 1'b0;
                addr     <= '0;
            end
            if (xfer) begin
                case (state)
                    S_LEN_HI: len_hi <= rx_data;
                    S_LEN_LO: begin
                        remaining <= len_full;
                        if (len_big) err <= 1'b1;
                    end
                    S_DAT_HI: hi_byte <= rx_data;
                    S_DAT_LO: begin
                        imem_we    <= 1'b1;
                        imem_addr  <= addr;
                        imem_wdata <= {hi_byte, rx_data};
                        addr       <= addr + 1'b1;
                        remaining  <= remaining - 1'b1;
                    end
                    S_CHK: begin
                        // Hold stays high on a bad image so it never executes.
                        if (rx_data == cksum) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, checksum/length errors, gaps, reset.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_req = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        imem_we;
    logic [12:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_hold, busy, done, err;

    int checks = 0;
    int failures = 0;
    int wr_count = 0;
    int wr_base;

    imem_loader #(.ADDR_W(13)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_req   (load_req),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (imem_we === 1'b1) wr_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic pulse_load();
        @(negedge clk) load_req = 1'b1;
        @(negedge clk) load_req = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles; returns #1 after the accepting edge.
    task automatic send(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout byte=%h", b);
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic check_wr(input string tag, input logic [12:0] a, input logic [15:0] d);
        check({tag, "_we"}, imem_we, 1);
        check({tag, "_addr"}, imem_addr, a);
        check({tag, "_data"}, imem_wdata, d);
    endtask

    // Frame 00 02 1234 ABCD; checksum is the XOR of all preceding bytes = 42.
    task automatic good_frame(input bit gaps, input bit req_mid);
        pulse_load();
        check("start_hold", cpu_hold, 1);
        check("start_busy", busy, 1);
        check("start_done_clr", done, 0);
        send(8'h00, gaps ? $urandom_range(0, 3) : 0);
        send(8'h02, gaps ? $urandom_range(0, 3) : 0);
        send(8'h12, gaps ? $urandom_range(0, 3) : 0);
        send(8'h34, gaps ? $urandom_range(0, 3) : 0);
        check_wr("w0", 13'd0, 16'h1234);
        if (req_mid) begin
            pulse_load();
            check("req_mid_busy", busy, 1);
        end
        send(8'hAB, gaps ? $urandom_range(0, 3) : 0);
        send(8'hCD, gaps ? $urandom_range(0, 3) : 0);
        check_wr("w1", 13'd1, 16'hABCD);
        send(8'h42, gaps ? $urandom_range(0, 3) : 0);
        check("good_done", done, 1);
        check("good_err", err, 0);
        check("good_hold", cpu_hold, 0);
        check("good_busy", busy, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_we", imem_we, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ready", rx_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", rx_ready, 0);

        // Contiguous good load
        good_frame(1'b0, 1'b0);

        // Bad checksum: both words still written, then error with hold kept
        wr_base = wr_count;
        pulse_load();
        send(8'h00, 0); send(8'h02, 0); send(8'h12, 0); send(8'h34, 0);
        send(8'hAB, 0); send(8'hCD, 0); send(8'h41, 0);
        check("bad_err", err, 1);
        check("bad_done", done, 0);
        check("bad_hold", cpu_hold, 1);
        @(negedge clk);
        check("bad_writes", wr_count - wr_base, 2);
        good_frame(1'b0, 1'b0);

        // Zero length
        wr_base = wr_count;
        pulse_load();
        send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        check("zero_done", done, 1);
        check("zero_hold", cpu_hold, 0);
        @(negedge clk);
        check("zero_writes", wr_count - wr_base, 0);
        pulse_load();
        send(8'h00, 0); send(8'h00, 0); send(8'h01, 0);
        check("zero_bad_err", err, 1);
        check("zero_bad_done", done, 0);

        // Oversize length 0x2001
        wr_base = wr_count;
        pulse_load();
        send(8'h20, 0); send(8'h01, 0);
        check("over_err", err, 1);
        check("over_ready", rx_ready, 0);
        @(negedge clk);
        check("over_ready_later", rx_ready, 0);
        check("over_hold", cpu_hold, 1);
        check("over_writes", wr_count - wr_base, 0);

        // Exactly 2^13 words is legal: lands in DAT_HI
        pulse_load();
        send(8'h20, 0); send(8'h00, 0);
        check("max_err", err, 0);
        check("max_ready", rx_ready, 1);
        check("max_busy", busy, 1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;

        // Gapped stream with a load_req during DAT_HI
        good_frame(1'b1, 1'b1);

        // Reset after the third data byte
        pulse_load();
        send(8'h00, 0); send(8'h02, 0); send(8'h12, 0); send(8'h34, 0); send(8'hAB, 0);
        @(negedge clk) rst = 1'b1;
        #1;
        check("mid_rst_hold", cpu_hold, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", rx_ready, 0);
        check("mid_rst_we", imem_we, 0);
        check("mid_rst_addr", imem_addr, 0);
        check("mid_rst_wdata", imem_wdata, 0);
        check("mid_rst_done_err", {done, err}, 0);
        @(negedge clk) rst = 1'b0;
        wr_base = wr_count;
        rx_data  = 8'hCD;
        rx_valid = 1'b1;
        repeat (5) @(negedge clk);
        rx_valid = 1'b0;
        check("post_rst_writes", wr_count - wr_base, 0);
        check("post_rst_ready", rx_ready, 0);
        good_frame(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
